// File: rtl/pool_window_ctrl.sv
// Sequencer for the 3x3 max-pooling engine: walks the input map window by window,
// gathers nine pixels, hands them to the engine and writes each result row-major.
module pool_window_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [15:0]       rd_data,
  output logic                     pool_valid_in,
  output logic [143:0]             pool_win,
  input  logic                     pool_valid_out,
  input  logic signed [15:0]       pool_max,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [15:0]       wr_data
);

  localparam int OUT_W = (IMG_W - 3) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - 3) / STRIDE + 1;

  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] OUT_W_A  = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] LAST_X   = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] LAST_Y   = ADDR_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [3:0]          c_q;
  logic [ADDR_W-1:0]   ox_q, oy_q;
  logic [ADDR_W-1:0]   ox_d, oy_d;
  logic [15:0]         win_q [9];
  logic                rd_en_q, pvi_q, wr_en_q, busy_q, done_q;
  logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
  logic signed [15:0]  wr_data_q;
  logic                last_win;

  // Input-map address of window element c (row-major inside the 3x3 window).
  function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] ox,
                                                 input logic [ADDR_W-1:0] oy,
                                                 input logic [3:0]        c);
    logic [ADDR_W-1:0] ky, kx;
    ky = (c >= 4'd6) ? ADDR_W'(2) : (c >= 4'd3) ? ADDR_W'(1) : ADDR_W'(0);
    kx = ADDR_W'(c) - ky * ADDR_W'(3);
    return (oy * STRIDE_A + ky) * IMG_W_A + ox * STRIDE_A + kx;
  endfunction

  always_comb begin
    last_win = (ox_q == LAST_X) && (oy_q == LAST_Y);
    ox_d     = ox_q + ONE_A;
    oy_d     = oy_q;
    if (ox_q == LAST_X) begin
      ox_d = '0;
      oy_d = oy_q + ONE_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      pvi_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_FETCH;
            c_q       <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= win_addr('0, '0, 4'd0);
          end
        end
        S_FETCH: begin
          // Data for the read issued at c-1 arrives at c.
          if (c_q != 4'd0) win_q[c_q - 4'd1] <= rd_data;
          if (c_q == 4'd9) begin
            state_q <= S_ISSUE;
            pvi_q   <= 1'b1;
            c_q     <= '0;
          end else begin
            c_q <= c_q + 4'd1;
          end
          if (c_q < 4'd8) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= win_addr(ox_q, oy_q, c_q + 4'd1);
          end else begin
            rd_en_q <= 1'b0;
          end
        end
        S_ISSUE: begin
          pvi_q   <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (pool_valid_out) begin
            wr_data_q <= pool_max;
            wr_en_q   <= 1'b1;
            wr_addr_q <= oy_q * OUT_W_A + ox_q;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          wr_en_q <= 1'b0;
          ox_q    <= ox_d;
          oy_q    <= oy_d;
          if (last_win) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= S_FETCH;
            c_q       <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= win_addr(ox_d, oy_d, 4'd0);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_win
      assign pool_win[16*gi +: 16] = win_q[gi];
    end
  endgenerate

  assign busy          = busy_q;
  assign done          = done_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign pool_valid_in = pvi_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Directed bench for pool_window_ctrl: three map geometries, each with its own
// SRAM and pooling-engine model, checked against hand-computed write sequences.
module tb_pool_window_ctrl;

  localparam int W_TAB[3] = '{4, 5, 3};
  localparam int H_TAB[3] = '{4, 5, 3};
  localparam int S_TAB[3] = '{1, 2, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               start_w[3], spur_w[3];
  int                 lat_w[3];
  logic               busy_w[3], done_w[3], rd_en_w[3], pvi_w[3], wr_en_w[3];
  logic [11:0]        rd_addr_w[3], wr_addr_w[3];
  logic signed [15:0] wr_data_w[3];
  logic [143:0]       pool_win_w[3];

  int n_tests = 0;
  int n_fail  = 0;

  int wr_a[$], wr_d[$], rd_a[$];
  int done_cyc, busy_bad, excl_bad, done_wide, gap;

  function automatic logic signed [15:0] pix(input int inst, input int a);
    if (inst == 2) begin
      if (a == 4) return -16'sd32768;
      if (a == 8) return -16'sd2;
      return -16'sd1;
    end
    return 16'(a);
  endfunction

  function automatic logic signed [15:0] win_max(input logic [143:0] w);
    logic signed [15:0] m, e;
    m = w[15:0];
    for (int k = 1; k < 9; k++) begin
      e = w[16*k +: 16];
      if (e > m) m = e;
    end
    return m;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      logic signed [15:0] rd_data_l = '0;
      logic signed [15:0] pend_val = '0;
      int                 pend_cnt = 0;
      logic               pvo_r = 1'b0;
      logic               pvo_l;

      assign pvo_l = pvo_r | spur_w[gi];

      pool_window_ctrl #(
        .IMG_W (W_TAB[gi]),
        .IMG_H (H_TAB[gi]),
        .STRIDE(S_TAB[gi]),
        .ADDR_W(12)
      ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_w[gi]),
        .busy          (busy_w[gi]),
        .done          (done_w[gi]),
        .rd_en         (rd_en_w[gi]),
        .rd_addr       (rd_addr_w[gi]),
        .rd_data       (rd_data_l),
        .pool_valid_in (pvi_w[gi]),
        .pool_win      (pool_win_w[gi]),
        .pool_valid_out(pvo_l),
        .pool_max      (pend_val),
        .wr_en         (wr_en_w[gi]),
        .wr_addr       (wr_addr_w[gi]),
        .wr_data       (wr_data_w[gi])
      );

      // Synchronous-read SRAM and a pooling engine with programmable latency.
      always @(posedge clk) begin
        if (rd_en_w[gi]) rd_data_l <= pix(gi, int'(rd_addr_w[gi]));
        pvo_r <= 1'b0;
        if (pend_cnt > 0) begin
          pend_cnt <= pend_cnt - 1;
          if (pend_cnt == 1) pvo_r <= 1'b1;
        end
        if (pvi_w[gi]) begin
          pend_val <= win_max(pool_win_w[gi]);
          if (lat_w[gi] <= 1) pvo_r <= 1'b1;
          else pend_cnt <= lat_w[gi] - 1;
        end
      end
    end
  endgenerate

  task automatic chk_eq(input string tag, input logic signed [143:0] got,
                        input logic signed [143:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one pass from a start pulse; must be called right after a negedge.
  task automatic run_pass(input int inst, input int spur_cyc, input int restart_cyc);
    int cyc;
    bit seen_done;
    int pvi_cyc;
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    done_cyc = -1; busy_bad = 0; excl_bad = 0; done_wide = 0; gap = -1;
    pvi_cyc = -1; seen_done = 0; cyc = 0;
    start_w[inst] = 1'b1;
    while (!seen_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start_w[inst] = (cyc == restart_cyc);
      spur_w[inst]  = (cyc == spur_cyc);
      if (rd_en_w[inst]) rd_a.push_back(int'(rd_addr_w[inst]));
      if (pvi_w[inst]) pvi_cyc = cyc;
      if (wr_en_w[inst]) begin
        wr_a.push_back(int'(wr_addr_w[inst]));
        wr_d.push_back(int'(wr_data_w[inst]));
        if (gap < 0 && pvi_cyc >= 0) gap = cyc - pvi_cyc;
        $display("[TB] inst %0d cycle %0d write addr %0d data %0d",
                 inst, cyc, wr_addr_w[inst], wr_data_w[inst]);
      end
      if (int'(rd_en_w[inst]) + int'(pvi_w[inst]) + int'(wr_en_w[inst]) > 1) excl_bad++;
      if (done_w[inst]) begin
        done_cyc  = cyc;
        seen_done = 1'b1;
        if (busy_w[inst]) busy_bad++;
      end else if (!busy_w[inst]) begin
        busy_bad++;
      end
    end
    start_w[inst] = 1'b0;
    spur_w[inst]  = 1'b0;
    @(negedge clk);
    if (done_w[inst] || busy_w[inst]) done_wide = 1;
  endtask

  task automatic check_writes(input string tag, input int n, input int ea[4], input int ed[4]);
    chk_eq({tag, "_nwr"}, wr_a.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wr_a.size()) begin
        chk_eq($sformatf("%s_addr%0d", tag, i), wr_a[i], ea[i]);
        chk_eq($sformatf("%s_data%0d", tag, i), wr_d[i], ed[i]);
      end
    end
  endtask

  initial begin
    int n_wr;
    int n_busy;
    int rd_exp[9];
    for (int i = 0; i < 3; i++) begin
      start_w[i] = 1'b0;
      spur_w[i]  = 1'b0;
      lat_w[i]   = 1;
    end
    rd_exp = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

    repeat (3) @(negedge clk);
    chk_eq("rst_busy",  busy_w[0], 0);
    chk_eq("rst_done",  done_w[0], 0);
    chk_eq("rst_rd_en", rd_en_w[0], 0);
    chk_eq("rst_pvi",   pvi_w[0], 0);
    chk_eq("rst_wr_en", wr_en_w[0], 0);
    chk_eq("rst_rd_addr", rd_addr_w[0], 0);
    chk_eq("rst_wr_addr", wr_addr_w[0], 0);
    chk_eq("rst_wr_data", wr_data_w[0], 0);
    chk_eq("rst_pool_win", pool_win_w[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4x4 stride 1, pixel = address
    run_pass(0, 0, 0);
    check_writes("t1", 4, '{0, 1, 2, 3}, '{10, 11, 14, 15});
    chk_eq("t1_done_cyc", done_cyc, 53);
    chk_eq("t1_busy", busy_bad, 0);
    chk_eq("t1_excl", excl_bad, 0);
    chk_eq("t1_done_wide", done_wide, 0);
    chk_eq("t1_nrd", rd_a.size(), 36);
    chk_eq("t1_gap", gap, 2);

    // 5x5 stride 2
    run_pass(1, 0, 0);
    check_writes("t2", 4, '{0, 1, 2, 3}, '{12, 14, 22, 24});
    for (int i = 0; i < 9; i++)
      if (i < rd_a.size()) chk_eq($sformatf("t2_rd%0d", i), rd_a[i], rd_exp[i]);
    chk_eq("t2_done_cyc", done_cyc, 53);

    // 3x3 with negative pixels
    run_pass(2, 0, 0);
    check_writes("t3", 1, '{0, 0, 0, 0}, '{-1, 0, 0, 0});
    chk_eq("t3_done_cyc", done_cyc, 14);
    chk_eq("t3_done_wide", done_wide, 0);

    // 4-cycle engine latency
    lat_w[0] = 4;
    run_pass(0, 0, 0);
    check_writes("t4", 4, '{0, 1, 2, 3}, '{10, 11, 14, 15});
    chk_eq("t4_gap", gap, 5);
    chk_eq("t4_done_cyc", done_cyc, 65);
    lat_w[0] = 1;

    // Reset during FETCH of the second window
    n_wr = 0;
    start_w[0] = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start_w[0] = 1'b0;
      if (wr_en_w[0]) n_wr++;
    end
    chk_eq("t5_wr_before", n_wr, 1);
    rst_n = 1'b0;
    #1;
    chk_eq("t5_rst_busy", busy_w[0], 0);
    chk_eq("t5_rst_rd_en", rd_en_w[0], 0);
    chk_eq("t5_rst_rd_addr", rd_addr_w[0], 0);
    chk_eq("t5_rst_wr_data", wr_data_w[0], 0);
    chk_eq("t5_rst_pool_win", pool_win_w[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_wr = 0;
    n_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (wr_en_w[0]) n_wr++;
      if (busy_w[0] || rd_en_w[0]) n_busy++;
    end
    chk_eq("t5_wr_after", n_wr, 0);
    chk_eq("t5_idle_after", n_busy, 0);
    run_pass(0, 0, 0);
    check_writes("t5r", 4, '{0, 1, 2, 3}, '{10, 11, 14, 15});
    chk_eq("t5r_done_cyc", done_cyc, 53);

    // Restart pulse while busy plus a stray pool_valid_out in FETCH
    run_pass(0, 3, 20);
    check_writes("t6", 4, '{0, 1, 2, 3}, '{10, 11, 14, 15});
    chk_eq("t6_done_cyc", done_cyc, 53);
    chk_eq("t6_busy", busy_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
